// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the handshaked data memory.
// Size codes, FSM state type and the byte-lane mask used by both the top
// level and the lane alignment block.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Little-endian lane mask; off is the already-aligned low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
// Stores: replicate right-aligned write data across lanes and merge the
// selected lanes into the current word. Loads: pick the addressed byte/half
// out of the word and sign- or zero-extend it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [31:0] steered;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // Store path: steer write data onto every lane, keep only masked lanes.
  always_comb begin
    mask = lane_mask(size, off);
    case (size)
      SZ_BYTE: steered = {4{wdata[7:0]}};
      SZ_HALF: steered = {2{wdata[15:0]}};
      default: steered = wdata;
    endcase
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[i*8 +: 8] = steered[i*8 +: 8];
    end
  end

  // Load path: extract the addressed lane(s) and extend to 32 bits.
  always_comb begin
    bsel = word[{off, 3'b000} +: 8];
    hsel = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h000000, bsel} : {{24{bsel[7]}}, bsel};
      SZ_HALF: rdata = is_unsigned ? {16'h0000, hsel}   : {{16{hsel[15]}}, hsel};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: word-organised data RAM behind a valid/ready request/response
// handshake with fixed access latency (LATENCY cycles from accept to
// rsp_valid). Byte/half/word access with sign/zero extension and error
// reporting for reserved size and out-of-range word index.
// Build option DMEM_MISALIGN_ERR_EN: when defined, misaligned half/word
// requests fault; otherwise the offending low address bits are cleared.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);
  localparam logic [3:0]        LAT_M1  = 4'(LATENCY - 1);

  state_t state, state_nxt;
  logic [3:0] cnt;

  logic              lat_we;
  logic              lat_uns;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic [31:0]       lat_wdata;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              sel_we;
  logic              sel_uns;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [31:0]       sel_wdata;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        off;
  logic              misalign;
  logic              err;
  logic [31:0]       word;
  logic [31:0]       merged;
  logic [31:0]       ext;

  assign accept = req_valid & req_ready;

  // RAM access happens on the edge entering RESP. With LATENCY==1 that is
  // the accept edge itself, so the live request is used instead of the latch.
  assign enter_resp = ((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                      ((state == ST_WAIT) && (cnt == 4'd1));

  // Select the request that is about to be serviced.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_we    = req_we;
      sel_uns   = req_unsigned;
      sel_addr  = req_addr;
      sel_size  = req_size;
      sel_wdata = req_wdata;
    end else begin
      sel_we    = lat_we;
      sel_uns   = lat_uns;
      sel_addr  = lat_addr;
      sel_size  = lat_size;
      sel_wdata = lat_wdata;
    end
  end

  // Address decode: word index, lane offset and fault detection.
  always_comb begin
    widx = {2'b00, sel_addr[ADDR_W-1:2]};
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = ((sel_size == SZ_HALF) && sel_addr[0]) ||
               ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
    off      = sel_addr[1:0];
`else
    misalign = 1'b0;
    case (sel_size)
      SZ_HALF: off = {sel_addr[1], 1'b0};
      SZ_WORD: off = 2'b00;
      default: off = sel_addr[1:0];
    endcase
`endif
    err  = (sel_size == 2'b11) || (widx >= DEPTH_L) || misalign;
    word = mem[widx[IDX_W-1:0]];
  end

  dmem_lane_align u_align (
    .size        (sel_size),
    .off         (off),
    .is_unsigned (sel_uns),
    .wdata       (sel_wdata),
    .word        (word),
    .merged      (merged),
    .rdata       (ext)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake flags are pure functions of state.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  // Latency counter: loaded on accept, counts down through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if ((state == ST_IDLE) && accept) begin
      cnt <= LAT_M1;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request latch: holds the accepted request through WAIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_uns   <= req_unsigned;
      lat_addr  <= req_addr;
      lat_size  <= req_size;
      lat_wdata <= req_wdata;
    end
  end

  // RAM write: faulted requests leave memory untouched.
  always_ff @(posedge clk) begin
    if (enter_resp && sel_we && !err) mem[widx[IDX_W-1:0]] <= merged;
  end

  // Response registers: captured on entry to RESP, held until handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= err;
      rsp_rdata <= (err || sel_we) ? 32'h0 : ext;
    end
  end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
- Parametrised successor to the single-cycle data memory: word-organised RAM behind a valid/ready request/response handshake.
- Supports byte, half and word access with sign/zero extension.
- Has configurable access latency and reports errors.
- Sits between the core's load/store stage and storage, so the core can stall on memory latency instead of assuming a same-cycle read.

Parameters:
- ADDR_W, 32, byte-address width of req_addr.
- DEPTH, 1024, number of 32-bit words; index = addr[ADDR_W-1:2]; legal 2..2^(ADDR_W-2).
- LATENCY, 2, cycles from request accept to rsp_valid; legal 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request faulted; no RAM side effect.

Behaviour:
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch request; go to RESP if LATENCY==1, else WAIT with cnt=LATENCY-1.
  - WAIT: req_ready=0. Decrement cnt each cycle; when cnt reaches 1, the next edge enters RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err stable until the rsp_valid&rsp_ready edge, then go to IDLE.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge. Maximum throughput is one request per LATENCY+1 cycles.
- RAM access happens on the edge entering RESP:
  - Store merges the selected byte lanes into the word.
  - Load samples the word, so it sees every earlier committed store.
- Lanes are little-endian: the byte at addr[1:0]=0 is [7:0]; the half at addr[1]=0 is [15:0].
- Store lanes: byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all four. Other lanes are unchanged.
- Load extension: byte/half extended per req_unsigned; word passed through.
- Error conditions (rsp_err=1, no write, rdata=0):
  - req_size=11.
  - Word index >= DEPTH.
  - Misalignment (see the optional feature).
- Reset mid-WAIT: the operation is aborted, a pending store is not committed, and the FSM returns to IDLE.
- Reset during RESP: the response is dropped.
- req_valid while not in IDLE is ignored; the requester must hold it.
- Response data must not change while rsp_valid=1 and rsp_ready=0.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, gives rsp_err=1 with no access.
- Undefined: offending low address bits are forced to zero (half clears addr[0], word clears addr[1:0]) and the access proceeds without error.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum {ST_IDLE, ST_WAIT, ST_RESP}.
  - Function computing the 4-bit lane mask from size and addr[1:0].
- Sub-module dmem_lane_align (combinational): store lane steering/merge and load extraction/extension.
- The top level holds the FSM, counter, request latch and RAM.

Test Plan:
- LATENCY=2. Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid exactly 2 cycles after each accept; rdata=0xDEADBEEF, err=0.
- After the above: load byte signed @0x13 -> 0xFFFFFFDE; load half unsigned @0x12 -> 0x0000DEAD; store byte 0x55 @0x11, then load word @0x10 -> 0xDEAD55EF.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable; req_ready=0 throughout; a new req_valid is not accepted until the cycle after the response handshake.
- With DMEM_MISALIGN_ERR_EN: store word @0x22 -> err=1 and memory unchanged. Without it: the same store writes word 0x20. Word index >= DEPTH (DEPTH=16, addr 0x40) -> err=1 in both builds.
- Reset asserted mid-WAIT of store 0x12345678 @0x8 (LATENCY=4) -> rsp_valid=0 and req_ready=1 immediately (async); a subsequent load @0x8 returns the prior contents.
- LATENCY=1, back-to-back store/load with rsp_ready tied 1 -> each response appears the cycle after accept; one accept every 2 cycles.
